shifter_arbiter: RTL and testbench

- Shares one combinational BarrelShifter among N requesters with a round-robin arbiter.
- Each requester presents operand, shift amount and opcode on a valid/ready handshake.
- The granted operation is computed by the shared shifter and captured in a one-deep output register tagged with the requester index.
- Sits between the datapath issue logic and the shifter so several functional paths can use one shifter.

---
 rtl/shifter_arbiter_pkg.sv | 13 +
 rtl/shifter_arbiter_barrel_shifter.sv | 36 +++
 rtl/shifter_arbiter_rr_arbiter.sv | 47 ++++
 rtl/shifter_arbiter.sv | 77 +++++++
 tb/tb_shifter_arbiter.sv | 205 ++++++++++++++++++++
 5 files changed

// File: rtl/shifter_arbiter_pkg.sv
// Shared definitions for the shifter arbiter: opcode encodings and size defaults.
package shifter_arbiter_pkg;

    localparam logic [1:0] SHIFT_OP_SHR = 2'b00;
    localparam logic [1:0] SHIFT_OP_SHL = 2'b01;
    localparam logic [1:0] SHIFT_OP_ROR = 2'b10;
    localparam logic [1:0] SHIFT_OP_ROL = 2'b11;

    localparam int WIDTH_DEFAULT = 16;
    localparam int LEVEL_DEFAULT = $clog2(WIDTH_DEFAULT);
    localparam int N_REQ_DEFAULT = 4;

endpackage

// File: rtl/shifter_arbiter_barrel_shifter.sv
// Combinational shifter/rotator shared by all requesters.
// Rotations use a doubled copy of the operand so the wrapped bits fall out
// of a single shift without needing a (width - b) term.
module barrel_shifter
    import shifter_arbiter_pkg::*;
#(
    parameter int width = WIDTH_DEFAULT,
    localparam int level = $clog2(width)
) (
    input  logic [width-1:0] a,
    input  logic [level-1:0] b,
    input  logic [1:0]       op,
    output logic [width-1:0] y
);

    logic [2*width-1:0] dbl;
    logic [2*width-1:0] ror_full;
    logic [2*width-1:0] rol_full;

    assign dbl      = {a, a};
    assign ror_full = dbl >> b;
    assign rol_full = dbl << b;

    // Select the operation result; b = 0 yields a for every opcode.
    always_comb begin
        y = a;
        case (op)
            SHIFT_OP_SHR: y = a >> b;
            SHIFT_OP_SHL: y = a << b;
            SHIFT_OP_ROR: y = ror_full[width-1:0];
            SHIFT_OP_ROL: y = rol_full[2*width-1:width];
            default:      y = a;
        endcase
    end

endmodule

// File: rtl/shifter_arbiter_rr_arbiter.sv
// Round-robin arbiter. The pointer names the highest-priority requester and
// moves just past the winner only when a grant is actually taken, so idle
// cycles leave priority where it was.
module rr_arbiter #(
    parameter int n = 4,
    localparam int id_w = $clog2(n)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [n-1:0]    req,
    input  logic            enable,
    input  logic            advance,
    output logic [n-1:0]    grant,
    output logic [id_w-1:0] grant_id
);

    logic [id_w-1:0] ptr;
    logic            found;

    // Search upward from the pointer (wrapping) for the first active request.
    always_comb begin
        int idx;
        grant    = '0;
        grant_id = '0;
        found    = 1'b0;
        idx      = 0;
        for (int k = 0; k < n; k++) begin
            idx = int'(ptr) + k;
            if (idx >= n) idx = idx - n;
            if (!found && req[idx]) begin
                found    = 1'b1;
                grant_id = id_w'(idx);
            end
        end
        if (enable && found) grant[grant_id] = 1'b1;
    end

    // Pointer register: step past the winner on each completed transfer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (advance) begin
            ptr <= (grant_id == id_w'(n - 1)) ? '0 : grant_id + id_w'(1);
        end
    end

endmodule

// File: rtl/shifter_arbiter.sv
// Shares one barrel shifter among n_req requesters. The granted payload is
// muxed into the shifter and the result lands in a one-deep output register
// tagged with the requester index. A new result may overwrite the register in
// the same cycle the consumer drains it.
module shifter_arbiter
    import shifter_arbiter_pkg::*;
#(
    parameter int width = WIDTH_DEFAULT,
    parameter int n_req = N_REQ_DEFAULT,
    localparam int level = $clog2(width),
    localparam int id_w  = $clog2(n_req)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [n_req-1:0]       req_valid,
    output logic [n_req-1:0]       req_ready,
    input  logic [n_req*width-1:0] req_a,
    input  logic [n_req*level-1:0] req_b,
    input  logic [n_req*2-1:0]     req_op,
    output logic                   resp_valid,
    output logic [id_w-1:0]        resp_id,
    output logic [width-1:0]       resp_y,
    input  logic                   resp_ready
);

    logic             accept;
    logic             transfer;
    logic [id_w-1:0]  grant_id;
    logic [width-1:0] sel_a;
    logic [level-1:0] sel_b;
    logic [1:0]       sel_op;
    logic [width-1:0] shift_y;

    // Reset gates accept so no grant is visible while rst_n is low.
    assign accept   = rst_n && (!resp_valid || resp_ready);
    assign transfer = |(req_valid & req_ready);

    rr_arbiter #(.n(n_req)) u_arb (
        .clk      (clk),
        .rst_n    (rst_n),
        .req      (req_valid),
        .enable   (accept),
        .advance  (transfer),
        .grant    (req_ready),
        .grant_id (grant_id)
    );

    // Route the winning requester's payload to the shared shifter.
    always_comb begin
        sel_a  = req_a[int'(grant_id)*width +: width];
        sel_b  = req_b[int'(grant_id)*level +: level];
        sel_op = req_op[int'(grant_id)*2 +: 2];
    end

    barrel_shifter #(.width(width)) u_shift (
        .a  (sel_a),
        .b  (sel_b),
        .op (sel_op),
        .y  (shift_y)
    );

    // Output register: load on transfer, drop valid on drain, hold otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resp_valid <= 1'b0;
            resp_y     <= '0;
            resp_id    <= '0;
        end else if (transfer) begin
            resp_valid <= 1'b1;
            resp_y     <= shift_y;
            resp_id    <= grant_id;
        end else if (resp_ready) begin
            resp_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_shifter_arbiter.sv
// Directed bench for shifter_arbiter (width=16, n_req=4). Inputs change on the
// falling edge; grants are checked shortly after, results just after the rising edge.
module tb_shifter_arbiter;

    logic        clk;
    logic        rst_n;
    logic [3:0]  req_valid;
    logic [3:0]  req_ready;
    logic [63:0] req_a;
    logic [15:0] req_b;
    logic [7:0]  req_op;
    logic        resp_valid;
    logic [1:0]  resp_id;
    logic [15:0] resp_y;
    logic        resp_ready;

    logic [15:0] a_v  [4];
    logic [3:0]  b_v  [4];
    logic [1:0]  op_v [4];

    int n_tests = 0;
    int n_fail  = 0;

    shifter_arbiter #(.width(16), .n_req(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_op     (req_op),
        .resp_valid (resp_valid),
        .resp_id    (resp_id),
        .resp_y     (resp_y),
        .resp_ready (resp_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        req_a  = '0;
        req_b  = '0;
        req_op = '0;
        for (int i = 0; i < 4; i++) begin
            req_a[i*16 +: 16] = a_v[i];
            req_b[i*4 +: 4]   = b_v[i];
            req_op[i*2 +: 2]  = op_v[i];
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic set_req(input int i, input logic [15:0] a, input logic [3:0] b, input logic [1:0] op);
        a_v[i]  = a;
        b_v[i]  = b;
        op_v[i] = op;
    endtask

    // Drive one operation on requester 0 and check grant and result.
    task automatic op0(input string tag, input logic [15:0] a, input logic [3:0] b,
                       input logic [1:0] op, input logic [15:0] exp_y);
        @(negedge clk);
        set_req(0, a, b, op);
        req_valid = 4'b0001;
        #1 chk({tag, "_ready"}, 32'(req_ready), 32'h1);
        @(posedge clk); #1;
        chk({tag, "_y"}, 32'(resp_y), 32'(exp_y));
        chk({tag, "_id"}, 32'(resp_id), 32'd0);
    endtask

    logic [3:0] rr_grant [6];
    initial begin
        rr_grant[0] = 4'b0001; rr_grant[1] = 4'b0010; rr_grant[2] = 4'b0100;
        rr_grant[3] = 4'b1000; rr_grant[4] = 4'b0001; rr_grant[5] = 4'b0010;
    end

    initial begin
        rst_n      = 1'b0;
        req_valid  = 4'b1111;
        resp_ready = 1'b1;
        for (int i = 0; i < 4; i++) set_req(i, 16'h0, 4'h0, 2'b00);

        // Reset state with requests pending
        #3;
        chk("rst_valid", 32'(resp_valid), 32'd0);
        chk("rst_y", 32'(resp_y), 32'd0);
        chk("rst_id", 32'(resp_id), 32'd0);
        chk("rst_ready", 32'(req_ready), 32'd0);
        @(negedge clk);
        rst_n     = 1'b1;
        req_valid = 4'b0000;

        // Single ROR on requester 2
        @(negedge clk);
        set_req(2, 16'h8001, 4'd4, 2'b10);
        req_valid = 4'b0100;
        #1 chk("ror_ready", 32'(req_ready), 32'h4);
        @(posedge clk); #1;
        chk("ror_valid", 32'(resp_valid), 32'd1);
        chk("ror_id", 32'(resp_id), 32'd2);
        chk("ror_y", 32'(resp_y), 32'h1800);

        // Opcode sweep on requester 0
        op0("shl8",   16'h00FF, 4'd8,  2'b01, 16'hFF00);
        op0("shr15",  16'h8000, 4'd15, 2'b00, 16'h0001);
        op0("rol1",   16'h8001, 4'd1,  2'b11, 16'h0003);
        op0("ror0",   16'h1234, 4'd0,  2'b10, 16'h1234);
        op0("rol0",   16'hA5C3, 4'd0,  2'b11, 16'hA5C3);
        op0("shr0",   16'h5A5A, 4'd0,  2'b00, 16'h5A5A);
        op0("shl0",   16'h8421, 4'd0,  2'b01, 16'h8421);
        op0("ror1",   16'h0001, 4'd1,  2'b10, 16'h8000);

        // Drain with no transfer keeps data, drops valid
        @(negedge clk);
        req_valid = 4'b0000;
        @(posedge clk); #1;
        chk("drain_valid", 32'(resp_valid), 32'd0);
        chk("drain_y", 32'(resp_y), 32'h8000);

        // Move pointer to 0 by granting requester 3 alone
        @(negedge clk);
        set_req(3, 16'h0011, 4'd3, 2'b01);
        req_valid = 4'b1000;
        @(posedge clk); #1;
        chk("pre_rr_id", 32'(resp_id), 32'd3);

        // Round robin with all four valid
        for (int i = 0; i < 4; i++) set_req(i, 16'h0011, 4'(i), 2'b01);
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            req_valid = 4'b1111;
            #1 chk($sformatf("rr_ready%0d", c), 32'(req_ready), 32'(rr_grant[c]));
            @(posedge clk); #1;
            chk($sformatf("rr_id%0d", c), 32'(resp_id), 32'(c % 4));
            chk($sformatf("rr_y%0d", c), 32'(resp_y), 32'(16'h0011 << (c % 4)));
        end

        // Backpressure: id 1 / y 0022 must hold
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            resp_ready = 1'b0;
            req_valid  = 4'b1111;
            #1 chk($sformatf("bp_ready%0d", c), 32'(req_ready), 32'd0);
            @(posedge clk); #1;
            chk($sformatf("bp_valid%0d", c), 32'(resp_valid), 32'd1);
            chk($sformatf("bp_id%0d", c), 32'(resp_id), 32'd1);
            chk($sformatf("bp_y%0d", c), 32'(resp_y), 32'h0022);
        end
        @(negedge clk);
        set_req(3, 16'h8001, 4'd4, 2'b10);
        req_valid  = 4'b1000;
        resp_ready = 1'b1;
        #1 chk("bp_release_ready", 32'(req_ready), 32'h8);
        @(posedge clk); #1;
        chk("bp_release_valid", 32'(resp_valid), 32'd1);
        chk("bp_release_id", 32'(resp_id), 32'd3);
        chk("bp_release_y", 32'(resp_y), 32'h1800);

        // Idle cycles must not rotate priority
        @(negedge clk);
        set_req(1, 16'h00F0, 4'd4, 2'b00);
        req_valid = 4'b0010;
        #1 chk("idle_g1_ready", 32'(req_ready), 32'h2);
        @(posedge clk);
        @(negedge clk);
        req_valid = 4'b0000;
        @(negedge clk);
        @(negedge clk);
        req_valid = 4'b1010;
        #1 chk("idle_hold_ready", 32'(req_ready), 32'h8);
        @(posedge clk); #1;
        chk("idle_hold_id", 32'(resp_id), 32'd3);

        // Async reset mid-stream
        for (int i = 0; i < 4; i++) set_req(i, 16'h0101 << i, 4'd0, 2'b00);
        @(negedge clk);
        req_valid = 4'b1111;
        @(posedge clk);
        @(posedge clk); #1;
        chk("pre_rst_id", 32'(resp_id), 32'd1);
        chk("pre_rst_y", 32'(resp_y), 32'h0202);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_valid", 32'(resp_valid), 32'd0);
        chk("arst_y", 32'(resp_y), 32'd0);
        chk("arst_ready", 32'(req_ready), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1 chk("post_rst_ready", 32'(req_ready), 32'h1);
        @(posedge clk); #1;
        chk("post_rst_id", 32'(resp_id), 32'd0);
        chk("post_rst_y", 32'(resp_y), 32'h0101);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
